// File: rtl/dct_lane_scheduler.sv
// Cuts a pixel stream into blocks and deals them round-robin to free DCT lanes.
// Optional DCT_SCHED_STATS_EN adds a saturating stall_cycles counter port.
module dct_lane_scheduler #(
   parameter int DATA_WIDTH = 10,
   parameter int LANES      = 3,
   parameter int BLOCK_SIZE = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] lane_data,
   output logic [LANES-1:0]      lane_valid,
   output logic                  lane_sof,
   output logic                  lane_eof,
   input  logic [LANES-1:0]      lane_done,
   output logic [LANES-1:0]      lane_busy,
`ifdef DCT_SCHED_STATS_EN
   output logic [15:0]           stall_cycles,
`endif
   output logic [15:0]           blocks_issued
);

   localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int CW = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;

   typedef enum logic {IDLE, STREAM} state_t;

   state_t          state_q, state_d;
   logic [LW-1:0]   rr_ptr, sel, pick;
   logic [LW:0]     sum;
   logic [CW-1:0]   cnt;
   logic [LANES-1:0] avail_busy, busy_d;
   logic            found, accept, last, grant;

   assign in_ready   = (state_q == STREAM);
   assign accept     = in_valid & in_ready;
   assign last       = accept && (cnt == CW'(BLOCK_SIZE - 1));
   assign avail_busy = lane_busy & ~lane_done;

   // Round-robin search starting at rr_ptr, honouring this cycle's done pulses.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      sum   = '0;
      for (int i = 0; i < LANES; i++) begin
         sum = {1'b0, rr_ptr} + (LW+1)'(i);
         if (sum >= (LW+1)'(LANES))
            sum = sum - (LW+1)'(LANES);
         if (!found && !avail_busy[sum[LW-1:0]]) begin
            found = 1'b1;
            pick  = sum[LW-1:0];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      grant   = 1'b0;
      busy_d  = avail_busy;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               grant   = 1'b1;
               busy_d  = avail_busy | (LANES'(1) << pick);
               state_d = STREAM;
            end
         end
         STREAM: begin
            if (last)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         lane_busy     <= '0;
         sel           <= '0;
         rr_ptr        <= '0;
         cnt           <= '0;
         lane_data     <= '0;
         lane_valid    <= '0;
         lane_sof      <= 1'b0;
         lane_eof      <= 1'b0;
         blocks_issued <= '0;
      end else begin
         state_q    <= state_d;
         lane_busy  <= busy_d;
         lane_valid <= '0;
         lane_sof   <= 1'b0;
         lane_eof   <= 1'b0;
         if (grant)
            sel <= pick;
         if (accept) begin
            lane_data  <= in_data;
            lane_valid <= LANES'(1) << sel;
            lane_sof   <= (cnt == '0);
            lane_eof   <= last;
            cnt        <= last ? '0 : cnt + 1'b1;
         end
         if (last) begin
            rr_ptr        <= (sel == LW'(LANES - 1)) ? '0 : sel + 1'b1;
            blocks_issued <= blocks_issued + 16'd1;
         end
      end
   end

`ifdef DCT_SCHED_STATS_EN
   always_ff @(posedge clk) begin
      if (rst)
         stall_cycles <= '0;
      else if (in_valid && !in_ready && stall_cycles != 16'hFFFF)
         stall_cycles <= stall_cycles + 16'd1;
   end
`endif

endmodule

// File: tb/tb_dct_lane_scheduler.sv
// Directed scoreboard bench for dct_lane_scheduler (LANES=3, BLOCK_SIZE=64).
module tb_dct_lane_scheduler;

   logic        clk;
   logic        rst;
   logic [9:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [9:0]  lane_data;
   logic [2:0]  lane_valid;
   logic        lane_sof;
   logic        lane_eof;
   logic [2:0]  lane_done;
   logic [2:0]  lane_busy;
   logic [15:0] blocks_issued;
`ifdef DCT_SCHED_STATS_EN
   logic [15:0] stall_cycles;
`endif

   typedef struct {
      int         lane;
      logic [9:0] data;
      logic       sof;
      logic       eof;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   pulses = 0;
   int   stall_exp = 0;

   dct_lane_scheduler #(
      .DATA_WIDTH(10), .LANES(3), .BLOCK_SIZE(64)
   ) dut (
      .clk(clk), .rst(rst),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .lane_data(lane_data), .lane_valid(lane_valid),
      .lane_sof(lane_sof), .lane_eof(lane_eof),
      .lane_done(lane_done), .lane_busy(lane_busy),
`ifdef DCT_SCHED_STATS_EN
      .stall_cycles(stall_cycles),
`endif
      .blocks_issued(blocks_issued)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (lane_valid !== 3'b000) begin
         pulses++;
         if (sb.size() == 0) begin
            chk("unexpected_pulse", {29'd0, lane_valid}, 32'd0);
         end else begin
            exp_t e;
            logic [2:0] one;
            e   = sb.pop_front();
            one = 3'b001 << e.lane;
            chk("lane_valid", {29'd0, lane_valid}, {29'd0, one});
            chk("lane_data", {22'd0, lane_data}, {22'd0, e.data});
            chk("lane_sof", {31'd0, lane_sof}, {31'd0, e.sof});
            chk("lane_eof", {31'd0, lane_eof}, {31'd0, e.eof});
         end
      end
   end

   task automatic step();
      if (in_valid && !in_ready && !rst && stall_exp != 65535)
         stall_exp++;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send_block(input int lane, input int base,
                             input bit gap, input int n);
      for (int k = 0; k < n; k++) begin
         int t;
         exp_t e;
         in_valid = 1'b1;
         in_data  = 10'(base + k * 10);
         t = 0;
         while (!in_ready && t < 100) begin
            step();
            t++;
         end
         if (!in_ready) begin
            chk("ready_timeout", {31'd0, in_ready}, 32'd1);
            in_valid = 1'b0;
            return;
         end
         e.lane = lane;
         e.data = in_data;
         e.sof  = (k == 0);
         e.eof  = (k == 63);
         sb.push_back(e);
         step();
         if (gap && k < n - 1) begin
            in_valid = 1'b0;
            step();
         end
      end
      in_valid = 1'b0;
   endtask

   initial begin
      int p0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      lane_done = '0;
      @(negedge clk);
      step();
      step();
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_lane_valid", {29'd0, lane_valid}, 32'd0);
      chk("rst_lane_data", {22'd0, lane_data}, 32'd0);
      chk("rst_sof_eof", {30'd0, lane_sof, lane_eof}, 32'd0);
      chk("rst_busy", {29'd0, lane_busy}, 32'd0);
      chk("rst_blocks", {16'd0, blocks_issued}, 32'd0);
      rst = 1'b0;

      // single block to lane 0
      send_block(0, 0, 1'b0, 64);
      chk("b1_in_ready_drop", {31'd0, in_ready}, 32'd0);
      chk("b1_blocks", {16'd0, blocks_issued}, 32'd1);
      chk("b1_busy", {29'd0, lane_busy}, 32'd1);

      // lanes 1 and 2, then all busy
      send_block(1, 1, 1'b0, 64);
      send_block(2, 2, 1'b0, 64);
      in_valid = 1'b1;
      in_data  = 10'd3;
      for (int i = 0; i < 5; i++) step();
      chk("full_in_ready", {31'd0, in_ready}, 32'd0);
      chk("full_busy", {29'd0, lane_busy}, 32'd7);
      chk("full_blocks", {16'd0, blocks_issued}, 32'd3);
`ifdef DCT_SCHED_STATS_EN
      chk("full_stall", {16'd0, stall_cycles}, stall_exp);
`endif
      lane_done = 3'b010;
      step();
      lane_done = 3'b000;
      chk("done1_grant_ready", {31'd0, in_ready}, 32'd1);
      chk("done1_busy", {29'd0, lane_busy}, 32'd7);
      send_block(1, 3, 1'b0, 64);
      chk("b4_blocks", {16'd0, blocks_issued}, 32'd4);

      // rr_ptr=2: free lane 0 to bring rr_ptr to 1
      lane_done = 3'b001;
      step();
      lane_done = 3'b000;
      send_block(0, 4, 1'b0, 64);
      chk("b5_busy", {29'd0, lane_busy}, 32'd7);
      lane_done = 3'b101;
      step();
      lane_done = 3'b000;
      chk("fair_busy", {29'd0, lane_busy}, 32'd6);
      send_block(2, 5, 1'b0, 64);
      chk("b6_busy", {29'd0, lane_busy}, 32'd6);

      // gapped block to lane 0
      p0 = pulses;
      send_block(0, 6, 1'b1, 64);
      chk("gap_pulses", pulses - p0, 32'd64);
      chk("gap_blocks", {16'd0, blocks_issued}, 32'd7);
      chk("gap_busy", {29'd0, lane_busy}, 32'd7);

      // partial block to lane 1, then reset
      lane_done = 3'b010;
      step();
      lane_done = 3'b000;
      send_block(1, 7, 1'b0, 30);
      rst = 1'b1;
      step();
      stall_exp = 0;
      chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("mid_rst_valid", {29'd0, lane_valid}, 32'd0);
      chk("mid_rst_data", {22'd0, lane_data}, 32'd0);
      chk("mid_rst_sof_eof", {30'd0, lane_sof, lane_eof}, 32'd0);
      chk("mid_rst_busy", {29'd0, lane_busy}, 32'd0);
      chk("mid_rst_blocks", {16'd0, blocks_issued}, 32'd0);
      rst = 1'b0;
      send_block(0, 8, 1'b0, 64);
      chk("post_rst_blocks", {16'd0, blocks_issued}, 32'd1);
      chk("post_rst_busy", {29'd0, lane_busy}, 32'd1);

      // spurious done on idle lane 2 while lane 1 streams
      step();
      lane_done = 3'b100;
      step();
      lane_done = 3'b000;
      chk("spur_busy", {29'd0, lane_busy}, 32'd3);
      chk("spur_ready", {31'd0, in_ready}, 32'd1);
      chk("spur_blocks", {16'd0, blocks_issued}, 32'd1);

      force dut.blocks_issued = 16'hFFFF;
      #1;
      release dut.blocks_issued;
      send_block(1, 9, 1'b0, 64);
      chk("wrap_blocks", {16'd0, blocks_issued}, 32'd0);
      chk("wrap_busy", {29'd0, lane_busy}, 32'd3);
`ifdef DCT_SCHED_STATS_EN
      chk("end_stall", {16'd0, stall_cycles}, stall_exp);
`endif
      step();
      chk("sb_empty", sb.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
